// File: rtl/scalar_writeback_arbiter.sv
// Write-port arbiter for the scalar register file: ALU results win, load returns
// wait in a small ordered FIFO whose entries can be killed by younger ALU writes.
module scalar_writeback_arbiter #(
    parameter int FIFO_DEPTH      = 4,
    parameter int REG_INDEX_WIDTH = 7,
    parameter int DATA_WIDTH      = 32
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       alu_valid_i,
    input  logic [REG_INDEX_WIDTH-1:0] alu_reg_i,
    input  logic [DATA_WIDTH-1:0]      alu_value_i,
    input  logic                       load_valid_i,
    input  logic [REG_INDEX_WIDTH-1:0] load_reg_i,
    input  logic [DATA_WIDTH-1:0]      load_value_i,
    output logic                       load_ready_o,
    input  logic [REG_INDEX_WIDTH-1:0] query_reg_i,
    output logic                       hazard_o,
    output logic                       write_enable_o,
    output logic [REG_INDEX_WIDTH-1:0] write_reg_o,
    output logic [DATA_WIDTH-1:0]      write_value_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [REG_INDEX_WIDTH-1:0] ent_reg_q  [FIFO_DEPTH];
    logic [REG_INDEX_WIDTH-1:0] ent_reg_d  [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]      ent_val_q  [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]      ent_val_d  [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]      ent_live_q;
    logic [FIFO_DEPTH-1:0]      ent_live_d;

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic                       we_q, we_d;
    logic [REG_INDEX_WIDTH-1:0] wreg_q, wreg_d;
    logic [DATA_WIDTH-1:0]      wval_q, wval_d;

    logic empty, xfer, pop, direct, push;
    logic [FIFO_DEPTH-1:0] occ;

    // Occupancy derives from distance past the read pointer, wrapping modulo depth.
    always_comb begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            occ[i] = ({1'b0, PW'(i) - rd_ptr_q} < count_q);
        end
    end

    always_comb begin
        hazard_o = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (occ[i] && ent_live_q[i] && ent_reg_q[i] == query_reg_i) begin
                hazard_o = 1'b1;
            end
        end
    end

    always_comb begin
        load_ready_o = (count_q != CW'(FIFO_DEPTH));
        empty        = (count_q == '0);
        xfer         = load_valid_i && load_ready_o;
        pop          = !alu_valid_i && !empty;
        direct       = !alu_valid_i && empty && xfer;
        push         = xfer && !direct;

        ent_reg_d  = ent_reg_q;
        ent_val_d  = ent_val_q;
        ent_live_d = ent_live_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        we_d       = 1'b0;
        wreg_d     = wreg_q;
        wval_d     = wval_q;

        if (alu_valid_i) begin
            we_d   = 1'b1;
            wreg_d = alu_reg_i;
            wval_d = alu_value_i;
        end else if (pop) begin
            we_d = ent_live_q[rd_ptr_q];
            if (ent_live_q[rd_ptr_q]) begin
                wreg_d = ent_reg_q[rd_ptr_q];
                wval_d = ent_val_q[rd_ptr_q];
            end
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else if (direct) begin
            we_d   = 1'b1;
            wreg_d = load_reg_i;
            wval_d = load_value_i;
        end

        // A younger ALU result supersedes any buffered load to the same register.
        if (alu_valid_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (ent_reg_q[i] == alu_reg_i) begin
                    ent_live_d[i] = 1'b0;
                end
            end
        end

        if (push) begin
            ent_reg_d[wr_ptr_q]  = load_reg_i;
            ent_val_d[wr_ptr_q]  = load_value_i;
            ent_live_d[wr_ptr_q] = !(alu_valid_i && load_reg_i == alu_reg_i);
            wr_ptr_d             = wr_ptr_q + PW'(1);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                ent_reg_q[i] <= '0;
                ent_val_q[i] <= '0;
            end
            ent_live_q <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            we_q       <= 1'b0;
            wreg_q     <= '0;
            wval_q     <= '0;
        end else begin
            ent_reg_q  <= ent_reg_d;
            ent_val_q  <= ent_val_d;
            ent_live_q <= ent_live_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            we_q       <= we_d;
            wreg_q     <= wreg_d;
            wval_q     <= wval_d;
        end
    end

    assign write_enable_o = we_q;
    assign write_reg_o    = wreg_q;
    assign write_value_o  = wval_q;

endmodule

// File: tb/tb_scalar_writeback_arbiter.sv
// Scoreboard bench for scalar_writeback_arbiter: ALU writes checked one cycle
// later, accepted loads queued in order and matched against non-ALU writes.
module tb_scalar_writeback_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        alu_valid_i;
    logic [6:0]  alu_reg_i;
    logic [31:0] alu_value_i;
    logic        load_valid_i;
    logic [6:0]  load_reg_i;
    logic [31:0] load_value_i;
    logic        load_ready_o;
    logic [6:0]  query_reg_i;
    logic        hazard_o;
    logic        write_enable_o;
    logic [6:0]  write_reg_o;
    logic [31:0] write_value_o;

    always #5 clk = ~clk;

    scalar_writeback_arbiter dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .alu_valid_i    (alu_valid_i),
        .alu_reg_i      (alu_reg_i),
        .alu_value_i    (alu_value_i),
        .load_valid_i   (load_valid_i),
        .load_reg_i     (load_reg_i),
        .load_value_i   (load_value_i),
        .load_ready_o   (load_ready_o),
        .query_reg_i    (query_reg_i),
        .hazard_o       (hazard_o),
        .write_enable_o (write_enable_o),
        .write_reg_o    (write_reg_o),
        .write_value_o  (write_value_o)
    );

    typedef struct packed {
        logic [6:0]  r;
        logic [31:0] v;
    } wr_t;

    wr_t         load_q[$];
    int          n_chk = 0;
    int          n_err = 0;
    int          wr_count = 0;
    logic [31:0] last33 = '0;
    logic        took;
    int          k;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic av, input logic [6:0] ar,
                        input logic [31:0] aval, input logic lv,
                        input logic [6:0] lr, input logic [31:0] lval,
                        output logic tk);
        wr_t e;
        @(negedge clk);
        alu_valid_i  = av;
        alu_reg_i    = ar;
        alu_value_i  = aval;
        load_valid_i = lv;
        load_reg_i   = lr;
        load_value_i = lval;
        #1;
        tk = lv && load_ready_o;
        if (av) begin
            for (int i = load_q.size() - 1; i >= 0; i--) begin
                if (load_q[i].r == ar) load_q.delete(i);
            end
        end
        if (tk && !(av && lr == ar)) load_q.push_back(wr_t'{r: lr, v: lval});
        @(posedge clk);
        #1;
        if (write_enable_o) wr_count++;
        if (write_enable_o && write_reg_o == 7'h33) last33 = write_value_o;
        if (av) begin
            check("alu_we", write_enable_o, 1);
            check("alu_reg", write_reg_o, ar);
            check("alu_val", write_value_o, aval);
        end else if (write_enable_o) begin
            if (load_q.size() == 0) begin
                check("unexpected_wr", {write_reg_o, write_value_o}, 0);
            end else begin
                e = load_q.pop_front();
                check("load_reg", write_reg_o, e.r);
                check("load_val", write_value_o, e.v);
            end
        end
    endtask

    task automatic idle();
        logic t;
        step(0, 0, 0, 0, 0, 0, t);
    endtask

    task automatic hz(input string tag, input logic [6:0] r, input logic exp);
        query_reg_i = r;
        #1;
        check(tag, hazard_o, exp);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 20 && load_q.size() > 0; i++) idle();
        check(tag, load_q.size(), 0);
        idle();
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n      = 1'b0;
        alu_valid_i  = 1'b0;
        alu_reg_i    = '0;
        alu_value_i  = '0;
        load_valid_i = 1'b0;
        load_reg_i   = '0;
        load_value_i = '0;
        query_reg_i  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_we", write_enable_o, 0);
        check("rst_reg", write_reg_o, 0);
        check("rst_val", write_value_o, 0);
        check("rst_ready", load_ready_o, 1);
        check("rst_hazard", hazard_o, 0);
        @(negedge clk);
        reset_n = 1'b1;

        step(0, 0, 0, 1, 7'h05, 32'hDEADBEEF, took);
        check("t1_we", write_enable_o, 1);
        check("t1_reg", write_reg_o, 7'h05);
        check("t1_val", write_value_o, 32'hDEADBEEF);
        hz("t1_no_buffer", 7'h05, 0);
        idle();
        check("t1_idle_we", write_enable_o, 0);
        check("t1_hold_val", write_value_o, 32'hDEADBEEF);

        step(1, 7'h10, 32'd1, 1, 7'h11, 32'd2, took);
        hz("t2_hazard", 7'h11, 1);
        hz("t2_other", 7'h10, 0);
        idle();
        check("t2_reg", write_reg_o, 7'h11);
        check("t2_val", write_value_o, 32'd2);
        hz("t2_hazard_gone", 7'h11, 0);

        k = 0;
        for (int i = 0; i < 6; i++) begin
            step(1, 7'(7'h40 + i), 32'(100 + i), 1, 7'(7'h20 + k),
                 32'(32'h1000 + k), took);
            if (took) k++;
        end
        check("t3_accepted", k, 4);
        check("t3_full", load_ready_o, 0);
        step(0, 0, 0, 1, 7'(7'h20 + k), 32'(32'h1000 + k), took);
        check("t3_full_reject", took, 0);
        check("t3_ready_back", load_ready_o, 1);
        for (int i = 0; i < 10 && k < 6; i++) begin
            step(0, 0, 0, 1, 7'(7'h20 + k), 32'(32'h1000 + k), took);
            if (took) k++;
        end
        check("t3_all_accepted", k, 6);
        drain("t3_drain");

        step(1, 7'h50, 32'd5, 1, 7'h07, 32'h77, took);
        hz("t4_hazard", 7'h07, 1);
        hz("t4_other", 7'h08, 0);
        step(1, 7'h07, 32'h99, 0, 0, 0, took);
        hz("t4_killed", 7'h07, 0);
        idle();
        check("t4_dead_pop", write_enable_o, 0);
        check("t4_keep_val", write_value_o, 32'h99);
        drain("t4_drain");

        step(1, 7'h60, 32'd1, 1, 7'h61, 32'h61, took);
        step(1, 7'h62, 32'd2, 1, 7'h63, 32'h63, took);
        step(1, 7'h33, 32'd1, 1, 7'h33, 32'd2, took);
        check("t5_took", took, 1);
        hz("t5_dead_in", 7'h33, 0);
        drain("t5_drain");
        check("t5_final33", last33, 32'd1);

        step(1, 7'h7a, 32'd3, 1, 7'h70, 32'h70, took);
        step(1, 7'h7b, 32'd4, 1, 7'h71, 32'h71, took);
        step(1, 7'h7c, 32'd5, 1, 7'h72, 32'h72, took);
        hz("t6_buffered", 7'h72, 1);
        @(negedge clk);
        alu_valid_i  = 1'b0;
        load_valid_i = 1'b0;
        reset_n      = 1'b0;
        #1;
        check("t6_rst_we", write_enable_o, 0);
        check("t6_rst_ready", load_ready_o, 1);
        hz("t6_rst_hazard", 7'h70, 0);
        load_q.delete();
        @(negedge clk);
        reset_n  = 1'b1;
        wr_count = 0;
        repeat (5) idle();
        check("t6_no_stale", wr_count, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
